log2_sched: RTL

//   Round-robin scheduler that shares one log2 pipeline (18b unsigned in, 21b Q5.16 out, 5-cycle fixed latency, no valid/reset) among N_CH requesters.

---
 rtl/log2_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/log2_sched.sv
// Round-robin scheduler sharing one fixed-latency log2 pipeline among N_CH requesters.
// Channel tags ride a shift register matched to the pipeline depth so each result returns to its issuer.
module log2_sched #(
  parameter int N_CH    = 4,
  parameter int LATENCY = 5,
  parameter int IN_W    = 18,
  parameter int OUT_W   = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      ch_en,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [N_CH*IN_W-1:0] req_data,
  output logic [N_CH-1:0]      req_ready,
  output logic [IN_W-1:0]      log_in,
  input  logic [OUT_W-1:0]     log_out,
  output logic [N_CH-1:0]      res_valid,
  output logic [OUT_W-1:0]     res_data,
  output logic                 res_zero,
  output logic                 busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   w_gidx;
  logic            w_found;
  logic            w_hs;
  logic            w_zero_op;
  logic            w_busy;
  logic [N_CH-1:0] w_cand;

  logic            r_tag_vld  [LATENCY];
  logic [CW-1:0]   r_tag_ch   [LATENCY];
  logic            r_tag_zero [LATENCY];

  assign w_cand = req_valid & ch_en;

  // First candidate at or after r_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end else begin
        idx = idx;
      end
      if (!w_found && w_cand[idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = idx[CW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // req_ready only ever selects a valid candidate, so a grant is a handshake.
  assign w_hs      = w_found & ~rst;
  assign req_ready = w_hs ? (N_CH'(1) << w_gidx) : '0;
  assign log_in    = w_hs ? req_data[w_gidx*IN_W +: IN_W] : '0;
  assign w_zero_op = (log_in == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_gidx == CW'(N_CH - 1)) ? '0 : w_gidx + CW'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_tag_vld[s]  <= 1'b0;
        r_tag_ch[s]   <= '0;
        r_tag_zero[s] <= 1'b0;
      end
    end else begin
      r_tag_vld[0]  <= w_hs;
      r_tag_ch[0]   <= w_gidx;
      r_tag_zero[0] <= w_zero_op;
      for (int s = 1; s < LATENCY; s++) begin
        r_tag_vld[s]  <= r_tag_vld[s-1];
        r_tag_ch[s]   <= r_tag_ch[s-1];
        r_tag_zero[s] <= r_tag_zero[s-1];
      end
    end
  end

  // log_out lines up with the last tag stage; log2(0) is undefined upstream, so force it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= '0;
      res_data  <= '0;
      res_zero  <= 1'b0;
    end else if (r_tag_vld[LATENCY-1]) begin
      res_valid <= N_CH'(1) << r_tag_ch[LATENCY-1];
      res_zero  <= r_tag_zero[LATENCY-1];
      res_data  <= r_tag_zero[LATENCY-1] ? '0 : log_out;
    end else begin
      res_valid <= '0;
      res_zero  <= 1'b0;
      res_data  <= res_data;
    end
  end

  always_comb begin
    w_busy = |res_valid;
    for (int s = 0; s < LATENCY; s++) begin
      w_busy = w_busy | r_tag_vld[s];
    end
  end

  assign busy = w_busy;

endmodule
